// File: rtl/ripple_accumulator_if.sv
// Operand stream from the ripple-carry adder plus the batch-result stream to the next stage.
// The accumulator sits on the slave side of both streams.
interface ripple_accumulator_if #(
    parameter int ACC_W = 12
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_sum;
    logic             in_cout;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_acc;
    logic             out_ovf;
    logic [7:0]       out_cnt;

    modport master (
        output in_valid, in_sum, in_cout, in_last, out_ready,
        input  in_ready, out_valid, out_acc, out_ovf, out_cnt
    );

    modport slave (
        input  in_valid, in_sum, in_cout, in_last, out_ready,
        output in_ready, out_valid, out_acc, out_ovf, out_cnt
    );
endinterface

// File: rtl/ripple_accumulator.sv
// Sums batches of 5-bit adder results; the total is valid the cycle after the final accept.
// The result is held until out_ready, and no operand is taken while it waits.
module ripple_accumulator #(
    parameter int ACC_W = 12,
    parameter int N_OPS = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    ripple_accumulator_if.slave bus
);
    typedef enum logic {ACCUM, HOLD} state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [ACC_W-1:0] r_acc;
    logic             r_ovf;
    logic [7:0]       r_cnt;
    logic [ACC_W-1:0] r_out_acc;
    logic             r_out_ovf;
    logic [7:0]       r_out_cnt;

    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_accept;
    logic             w_batch_end;
    logic             w_release;
    logic [ACC_W:0]   w_operand;
    logic [ACC_W:0]   w_sum;

    // Bit ACC_W of the widened sum is the carry out of the accumulator MSB.
    assign w_operand = {{(ACC_W-4){1'b0}}, bus.in_cout, bus.in_sum};
    assign w_sum     = {1'b0, r_acc} + w_operand;

    assign w_accept    = bus.in_valid & w_in_ready;
    assign w_batch_end = w_accept & (bus.in_last | (r_cnt == 8'(N_OPS - 1)));
    assign w_release   = w_out_valid & bus.out_ready;

    always_comb begin
        w_next_state = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        case (r_state)
            ACCUM: begin
                w_in_ready = rst_n;
                if (w_batch_end) begin
                    w_next_state = HOLD;
                end
            end
            HOLD: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_next_state = ACCUM;
                end
            end
            default: w_next_state = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Separate output copies keep the result ports at zero while a batch is being summed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc     <= '0;
            r_ovf     <= 1'b0;
            r_cnt     <= '0;
            r_out_acc <= '0;
            r_out_ovf <= 1'b0;
            r_out_cnt <= '0;
        end else if (w_accept) begin
            r_acc <= w_sum[ACC_W-1:0];
            r_ovf <= r_ovf | w_sum[ACC_W];
            r_cnt <= r_cnt + 8'd1;
            if (w_batch_end) begin
                r_out_acc <= w_sum[ACC_W-1:0];
                r_out_ovf <= r_ovf | w_sum[ACC_W];
                r_out_cnt <= r_cnt + 8'd1;
            end
        end else if (w_release) begin
            r_acc     <= '0;
            r_ovf     <= 1'b0;
            r_cnt     <= '0;
            r_out_acc <= '0;
            r_out_ovf <= 1'b0;
            r_out_cnt <= '0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_acc   = r_out_acc;
    assign bus.out_ovf   = r_out_ovf;
    assign bus.out_cnt   = r_out_cnt;
endmodule

// File: tb/tb_ripple_accumulator.sv
// Directed bench: a 12-bit and a 7-bit accumulator (N_OPS = 8) share one stimulus stream.
module tb_ripple_accumulator;
    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] in_sum;
    logic       in_cout;
    logic       in_last;
    logic       out_ready;
    int         n_checks;
    int         n_pass;

    ripple_accumulator_if #(.ACC_W(12)) b12 ();
    ripple_accumulator_if #(.ACC_W(7))  b7 ();

    assign b12.in_valid  = in_valid;
    assign b12.in_sum    = in_sum;
    assign b12.in_cout   = in_cout;
    assign b12.in_last   = in_last;
    assign b12.out_ready = out_ready;
    assign b7.in_valid   = in_valid;
    assign b7.in_sum     = in_sum;
    assign b7.in_cout    = in_cout;
    assign b7.in_last    = in_last;
    assign b7.out_ready  = out_ready;

    ripple_accumulator #(.ACC_W(12), .N_OPS(8)) dut12 (.clk(clk), .rst_n(rst_n), .bus(b12));
    ripple_accumulator #(.ACC_W(7),  .N_OPS(8)) dut7  (.clk(clk), .rst_n(rst_n), .bus(b7));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic [4:0] v, input logic last);
        in_valid = 1'b1;
        {in_cout, in_sum} = v;
        in_last = last;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
        {in_cout, in_sum} = 5'd0;
    endtask

    task automatic run_batch(input int n, input logic [4:0] v, input logic last_at_end);
        for (int i = 0; i < n; i++) begin
            drive_op(v, last_at_end && (i == n - 1));
            tick();
        end
        idle();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; out_ready = 1'b0; drive_op(5'd31, 1'b0);
        tick(); tick();
        n_checks++; if (b12.in_ready !== 1'b0) $display("FAIL reset_in_ready got %b want 0", b12.in_ready); else n_pass++;
        n_checks++; if (b12.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", b12.out_valid); else n_pass++;
        n_checks++; if (b12.out_acc !== 12'd0 || b12.out_cnt !== 8'd0 || b12.out_ovf !== 1'b0)
            $display("FAIL reset_outputs got acc=%0d cnt=%0d ovf=%b want 0/0/0", b12.out_acc, b12.out_cnt, b12.out_ovf); else n_pass++;
        idle();
        rst_n = 1'b1;
        #1;
        n_checks++; if (b12.in_ready !== 1'b1) $display("FAIL reset_release_in_ready got %b want 1", b12.in_ready); else n_pass++;
    endtask

    task automatic test_full_batch();
        out_ready = 1'b1;
        run_batch(8, 5'd31, 1'b0);
        n_checks++; if (b12.out_valid !== 1'b1) $display("FAIL full_out_valid got %b want 1", b12.out_valid); else n_pass++;
        n_checks++; if (b12.out_acc !== 12'd248) $display("FAIL full_acc got %0d want 248", b12.out_acc); else n_pass++;
        n_checks++; if (b12.out_ovf !== 1'b0) $display("FAIL full_ovf got %b want 0", b12.out_ovf); else n_pass++;
        n_checks++; if (b12.out_cnt !== 8'd8) $display("FAIL full_cnt got %0d want 8", b12.out_cnt); else n_pass++;
        n_checks++; if (b12.in_ready !== 1'b0) $display("FAIL full_hold_in_ready got %b want 0", b12.in_ready); else n_pass++;
        n_checks++; if (b7.out_acc !== 7'd120) $display("FAIL ovf7_acc got %0d want 120", b7.out_acc); else n_pass++;
        n_checks++; if (b7.out_ovf !== 1'b1) $display("FAIL ovf7_flag got %b want 1", b7.out_ovf); else n_pass++;
        tick();
        n_checks++; if (b12.in_ready !== 1'b1) $display("FAIL full_ready_back got %b want 1", b12.in_ready); else n_pass++;
        n_checks++; if (b12.out_valid !== 1'b0) $display("FAIL full_valid_drop got %b want 0", b12.out_valid); else n_pass++;
        n_checks++; if (b12.out_acc !== 12'd0) $display("FAIL full_acc_cleared got %0d want 0", b12.out_acc); else n_pass++;
    endtask

    task automatic test_overflow_clear();
        out_ready = 1'b1;
        run_batch(8, 5'd1, 1'b0);
        n_checks++; if (b7.out_acc !== 7'd8) $display("FAIL ovf7_next_acc got %0d want 8", b7.out_acc); else n_pass++;
        n_checks++; if (b7.out_ovf !== 1'b0) $display("FAIL ovf7_sticky_cleared got %b want 0", b7.out_ovf); else n_pass++;
        n_checks++; if (b12.out_acc !== 12'd8) $display("FAIL ones_acc got %0d want 8", b12.out_acc); else n_pass++;
        tick();
    endtask

    task automatic test_early_end();
        out_ready = 1'b1;
        drive_op(5'd5, 1'b0); tick();
        idle(); tick(); tick();
        n_checks++; if (b12.out_valid !== 1'b0) $display("FAIL gap_no_valid got %b want 0", b12.out_valid); else n_pass++;
        drive_op(5'd10, 1'b0); tick();
        drive_op(5'd31, 1'b1); tick();
        idle();
        n_checks++; if (b12.out_valid !== 1'b1) $display("FAIL early_valid got %b want 1", b12.out_valid); else n_pass++;
        n_checks++; if (b12.out_acc !== 12'd46) $display("FAIL early_acc got %0d want 46", b12.out_acc); else n_pass++;
        n_checks++; if (b12.out_cnt !== 8'd3) $display("FAIL early_cnt got %0d want 3", b12.out_cnt); else n_pass++;
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        run_batch(8, 5'd1, 1'b0);
        drive_op(5'd7, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++; if (b12.out_valid !== 1'b1 || b12.in_ready !== 1'b0)
                $display("FAIL bp_handshake cyc %0d got valid=%b ready=%b want 1/0", i, b12.out_valid, b12.in_ready); else n_pass++;
            n_checks++; if (b12.out_acc !== 12'd8 || b12.out_cnt !== 8'd8 || b12.out_ovf !== 1'b0)
                $display("FAIL bp_hold cyc %0d got acc=%0d cnt=%0d ovf=%b want 8/8/0", i, b12.out_acc, b12.out_cnt, b12.out_ovf); else n_pass++;
        end
        idle();
        out_ready = 1'b1;
        tick();
        n_checks++; if (b12.out_valid !== 1'b0) $display("FAIL bp_release got %b want 0", b12.out_valid); else n_pass++;
        run_batch(8, 5'd1, 1'b0);
        n_checks++; if (b12.out_acc !== 12'd8 || b12.out_cnt !== 8'd8)
            $display("FAIL bp_next_batch got acc=%0d cnt=%0d want 8/8", b12.out_acc, b12.out_cnt); else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid_batch();
        out_ready = 1'b1;
        run_batch(4, 5'd9, 1'b0);
        drive_op(5'd9, 1'b0);
        rst_n = 1'b0;
        #1;
        n_checks++; if (b12.in_ready !== 1'b0) $display("FAIL rst_mid_in_ready got %b want 0", b12.in_ready); else n_pass++;
        tick();
        n_checks++; if (b12.out_valid !== 1'b0 || b12.out_acc !== 12'd0 || b12.out_cnt !== 8'd0 || b12.out_ovf !== 1'b0)
            $display("FAIL rst_mid_outputs got v=%b acc=%0d cnt=%0d ovf=%b want 0", b12.out_valid, b12.out_acc, b12.out_cnt, b12.out_ovf); else n_pass++;
        idle();
        rst_n = 1'b1;
        run_batch(8, 5'd2, 1'b0);
        n_checks++; if (b12.out_acc !== 12'd16) $display("FAIL rst_next_acc got %0d want 16", b12.out_acc); else n_pass++;
        n_checks++; if (b12.out_cnt !== 8'd8) $display("FAIL rst_next_cnt got %0d want 8", b12.out_cnt); else n_pass++;
        tick();
    endtask

    task automatic test_last_on_nth();
        out_ready = 1'b1;
        run_batch(8, 5'd3, 1'b1);
        n_checks++; if (b12.out_valid !== 1'b1) $display("FAIL last_nth_valid got %b want 1", b12.out_valid); else n_pass++;
        n_checks++; if (b12.out_acc !== 12'd24 || b12.out_cnt !== 8'd8)
            $display("FAIL last_nth_result got acc=%0d cnt=%0d want 24/8", b12.out_acc, b12.out_cnt); else n_pass++;
        tick();
        n_checks++; if (b12.out_valid !== 1'b0) $display("FAIL last_nth_release got %b want 0", b12.out_valid); else n_pass++;
        tick();
        n_checks++; if (b12.out_valid !== 1'b0 || b12.in_ready !== 1'b1)
            $display("FAIL last_nth_no_empty got valid=%b ready=%b want 0/1", b12.out_valid, b12.in_ready); else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        idle();
        test_reset();
        test_full_batch();
        test_overflow_clear();
        test_early_end();
        test_backpressure();
        test_reset_mid_batch();
        test_last_on_nth();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/ripple_accumulator.md
# ripple_accumulator

Downstream consumer of the 4-bit ripple-carry adder. It takes each adder result (4-bit sum plus carry-out) as one 5-bit operand over a valid/ready handshake and accumulates a batch of operands into a wide register. When the batch completes, it presents the total with a sticky overflow flag and holds it until the next stage accepts it. The block then clears itself and starts the next batch.

## Interface
- ACC_W, default 12: accumulator and result width in bits; legal range 6..32.
- N_OPS, default 8: operands per batch; legal range 1..255.

- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous and active-low; sampled on the rising edge of clk.
- in_valid  input  1  the operand on in_sum/in_cout is valid.
- in_ready  output  1  the block can accept an operand.
- in_sum  input  4  adder sum bits.
- in_cout  input  1  adder carry-out; operand = {in_cout, in_sum}, value range 0..31, zero-extended to ACC_W.
- in_last  input  1  qualified by in_valid; this operand ends the batch early.
- out_valid  output  1  out_acc/out_ovf/out_cnt hold a completed batch.
- out_ready  input  1  the downstream stage accepts the result.
- out_acc  output  ACC_W  batch total, modulo 2^ACC_W.
- out_ovf  output  1  sticky: at least one addition in the batch carried out of bit ACC_W-1.
- out_cnt  output  8  number of operands in the batch (1..N_OPS).

## Operation
- Two-state FSM: ACCUM and HOLD.
- Reset (rst_n low at an edge):
  - state ← ACCUM; acc, cnt, ovf ← 0.
  - Outputs: out_valid = 0, out_acc = 0, out_ovf = 0, out_cnt = 0.
  - in_ready is forced to 0 while rst_n is low.
- Accept = in_valid & in_ready.
- ACCUM:
  - in_ready = 1, out_valid = 0.
  - On accept: acc ← (acc + operand) mod 2^ACC_W; ovf ← ovf | carry out of bit ACC_W-1; cnt ← cnt + 1.
  - If the accept is the N_OPS-th operand (cnt == N_OPS-1) or in_last = 1, go to HOLD. The same edge loads the post-add values into acc/ovf/cnt.
  - No accept: all state holds.
- HOLD:
  - in_ready = 0, out_valid = 1; out_acc = acc, out_ovf = ovf, out_cnt = cnt.
  - Any in_valid is ignored and no operand is consumed.
  - On out_valid & out_ready: acc, cnt, ovf ← 0; go to ACCUM.
- out_acc/out_ovf/out_cnt are driven straight from registers and are stable throughout HOLD. They read 0 while in ACCUM.
- Both batch-end conditions in the same accept (in_last on the N_OPS-th operand) end a single batch; out_cnt = N_OPS.
- With N_OPS = 1, every accepted operand is its own batch.
- Reset takes priority over every other event, including an accept or out_ready in the same cycle. A batch in progress is discarded and no partial result is emitted.

## Timing
- in_ready is combinational from state and rst_n only; it never depends on in_valid.
- out_valid is registered state; it has no combinational path from any input.
- Latency: the result is visible (out_valid = 1) in the cycle after the final operand is accepted.
- Throughput: one operand per cycle in ACCUM. Each batch costs at least one HOLD cycle, so N_OPS operands occupy at least N_OPS+1 cycles.
- out_valid stays high, with stable data, until out_ready is sampled high. It drops in the cycle after the handshake, and in_ready rises in that same cycle.
- Gaps in in_valid stall accumulation without penalty. The count includes only accepted operands.

## Test plan
- Full batch, defaults: 8 accepts of {1,1111} (31) back-to-back, out_ready = 1 → out_valid one cycle after the 8th accept; out_acc = 248, out_ovf = 0, out_cnt = 8; in_ready = 0 for exactly one cycle.
- Overflow, ACC_W = 7: same 8×31 stimulus → out_acc = 120 (248 mod 128), out_ovf = 1; the next batch of 8×1 gives out_acc = 8, out_ovf = 0 (sticky flag cleared between batches).
- Early end: operands 5, 10, then 31 with in_last, with two idle cycles between the 1st and 2nd → out_acc = 46, out_cnt = 3; no extra cycles are counted for the gaps.
- Backpressure: complete a batch, then hold out_ready = 0 for 5 cycles while driving in_valid = 1 with operand 7 → out_acc, out_ovf and out_cnt are unchanged, in_ready = 0, and nothing is accumulated. After out_ready rises, the next batch starts from 0.
- Reset mid-batch: accept 4 operands, then pulse rst_n low for one edge together with in_valid → all outputs are 0; a following 8×2 batch gives out_acc = 16, out_cnt = 8.
- in_last on the N_OPS-th operand: 8 operands of 3 with in_last on the 8th → a single result, out_acc = 24, out_cnt = 8, and no empty follow-on batch.
